// File: rtl/packed_deser_pkg.sv
// Shared types and constants for the packed-word deserializer slice.
// Optional X/Z frame check is enabled by defining PACKED_DESER_XCHECK_EN.
package packed_deser_pkg;

  localparam int DEF_SLICE_W = 4;
  localparam int DEF_D1      = 3;
  localparam int DEF_D2      = 4;
  localparam int DEF_D3      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } deser_state_e;

  // Flat bit position of slice k inside the assembled word.
  function automatic int slice_offset(input int k, input int slice_w = DEF_SLICE_W);
    return k * slice_w;
  endfunction

endpackage

// File: rtl/deser_slice_counter.sv
// Slot counter for the deserializer: counts accepted slices of the current frame,
// saturating at N so it can never wrap.
module deser_slice_counter #(
  parameter int N     = 60,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             is_last_slot
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != CNT_W'(N))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count        = count_reg;
  assign is_last_slot = (count_reg == CNT_W'(N - 1));

endmodule

// File: rtl/packed_word_deserializer.sv
// Assembles SLICE_W-bit slices into one [D3][D2][D1][SLICE_W] packed word with frame flags.
// Define PACKED_DESER_XCHECK_EN to add the out_xz port and its X/Z detection.
module packed_word_deserializer
  import packed_deser_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int D1      = DEF_D1,
  parameter int D2      = DEF_D2,
  parameter int D3      = DEF_D3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SLICE_W-1:0]                        in_data,
  input  logic                                      in_last,
  input  logic                                      in_flush,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [D3-1:0][D2-1:0][D1-1:0][SLICE_W-1:0] out_data,
  output logic                                      out_short,
`ifdef PACKED_DESER_XCHECK_EN
  output logic                                      out_xz,
`endif
  output logic                                      out_nolast
);

  localparam int N_SLICES = D1 * D2 * D3;
  localparam int WORD_W   = N_SLICES * SLICE_W;
  localparam int CNT_W    = $clog2(N_SLICES + 1);

  deser_state_e     state_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             short_reg;
  logic             nolast_reg;
  logic [CNT_W-1:0] count;
  logic             is_last_slot;
  logic [WORD_W-1:0] word_flat;

  logic flush_eff;
  logic slice_xfer;
  logic word_xfer;
  logic clr_buf;
  logic short_end;

  // Flush only matters while a frame is still open; a committed word is untouchable.
  assign flush_eff  = in_flush && (state_reg != HOLD);
  assign slice_xfer = in_valid && in_ready_reg && !flush_eff;
  assign word_xfer  = out_valid_reg && out_ready;
  assign clr_buf    = flush_eff || word_xfer;
  assign short_end  = slice_xfer && in_last && !is_last_slot;

  deser_slice_counter #(
    .N     (N_SLICES),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .inc          (slice_xfer),
    .clr          (clr_buf),
    .count        (count),
    .is_last_slot (is_last_slot)
  );

  // One register per slot; buffer is zero between frames so a short frame is zero-padded.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLICES; gi++) begin : g_slot
      logic [SLICE_W-1:0] slot_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (clr_buf) begin
          slot_reg <= '0;
        end else if (slice_xfer && (count == CNT_W'(gi))) begin
          slot_reg <= in_data;
        end else if (short_end && (count < CNT_W'(gi))) begin
          slot_reg <= '0;
        end
      end

      assign word_flat[slice_offset(gi, SLICE_W) +: SLICE_W] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      short_reg     <= 1'b0;
      nolast_reg    <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE, FILL: begin
          in_ready_reg <= 1'b1;
          if (flush_eff) begin
            state_reg  <= IDLE;
            short_reg  <= 1'b0;
            nolast_reg <= 1'b0;
          end else if (slice_xfer) begin
            if (is_last_slot) begin
              state_reg     <= HOLD;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              short_reg     <= 1'b0;
              nolast_reg    <= !in_last;
            end else if (in_last) begin
              state_reg     <= HOLD;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              short_reg     <= 1'b1;
              nolast_reg    <= 1'b0;
            end else begin
              state_reg <= FILL;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            short_reg     <= 1'b0;
            nolast_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          short_reg     <= 1'b0;
          nolast_reg    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PACKED_DESER_XCHECK_EN
  logic xz_reg;
  logic slice_xz;

  // Reduction XOR collapses to X whenever any bit of the slice is X or Z.
  assign slice_xz = ((^in_data) === 1'bx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xz_reg <= 1'b0;
    end else if (clr_buf) begin
      xz_reg <= 1'b0;
    end else if (slice_xfer && slice_xz) begin
      xz_reg <= 1'b1;
    end
  end

  assign out_xz = xz_reg;
`endif

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_short  = short_reg;
  assign out_nolast = nolast_reg;
  assign out_data   = word_flat;

endmodule

// File: tb/tb_packed_word_deserializer.sv
// Directed bench for packed_word_deserializer: hand-computed frames, flags, backpressure,
// flush and async reset. Define PACKED_DESER_XCHECK_EN to also exercise out_xz.
module tb_packed_word_deserializer;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [3:0]              in_data = '0;
  logic                    in_last = 1'b0;
  logic                    in_flush = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [4:0][3:0][2:0][3:0] out_data;
  logic                    out_short;
  logic                    out_nolast;
`ifdef PACKED_DESER_XCHECK_EN
  logic                    out_xz;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [3:0]   slices [60];
  logic [239:0] exp_word;

  always #5 clk = ~clk;

  packed_word_deserializer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_short  (out_short),
`ifdef PACKED_DESER_XCHECK_EN
    .out_xz     (out_xz),
`endif
    .out_nolast (out_nolast)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Expected word: slice k at flat bits [4k+:4] for k < n, zeros above.
  task automatic build_exp(input int n);
    exp_word = '0;
    for (int k = 0; k < n; k++) exp_word[k*4 +: 4] = slices[k];
  endtask

  task automatic send_slice(input logic [3:0] d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("in_ready_timeout", 256'(in_ready), 256'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input logic last_at_hi);
    for (int k = lo; k <= hi; k++) send_slice(slices[k], (k == hi) ? last_at_hi : 1'b0);
  endtask

  task automatic pop_word();
    int guard;
    guard     = 0;
    out_ready = 1'b1;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("out_valid_timeout", 256'(out_valid), 256'(1'b1));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_in_ready", 256'(in_ready), 256'(1'b0));
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_out_short", 256'(out_short), 256'(1'b0));
    chk("rst_out_nolast", 256'(out_nolast), 256'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 256'(in_ready), 256'(1'b1));

    // Full frame: slice k = k[3:0], in_last on slice 59
    for (int k = 0; k < 60; k++) slices[k] = 4'(k);
    send_range(0, 58, 1'b0);
    chk("full_pre_valid", 256'(out_valid), 256'(1'b0));
    send_range(59, 59, 1'b1);
    build_exp(60);
    chk("full_valid", 256'(out_valid), 256'(1'b1));
    chk("full_d000", 256'(out_data[0][0][0]), 256'(4'h0));
    chk("full_d001", 256'(out_data[0][0][1]), 256'(4'h1));
    chk("full_d432", 256'(out_data[4][3][2]), 256'(4'hB));
    chk("full_word", 256'(out_data), 256'(exp_word));
    chk("full_short", 256'(out_short), 256'(1'b0));
    chk("full_nolast", 256'(out_nolast), 256'(1'b0));
    chk("full_in_ready", 256'(in_ready), 256'(1'b0));
    pop_word();
    chk("full_popped", 256'(out_valid), 256'(1'b0));

    // Short frame: 7 x 4'hF, last on slice 6
    for (int k = 0; k < 7; k++) slices[k] = 4'hF;
    send_range(0, 6, 1'b1);
    chk("short_valid", 256'(out_valid), 256'(1'b1));
    chk("short_word", 256'(out_data), {16'h0, 212'h0, 28'hFFF_FFFF});
    chk("short_flag", 256'(out_short), 256'(1'b1));
    chk("short_nolast", 256'(out_nolast), 256'(1'b0));
    pop_word();
    chk("short_clear", 256'(out_short), 256'(1'b0));

    // 60 slices with no in_last: nolast boundary
    for (int k = 0; k < 60; k++) slices[k] = 4'(k * 7);
    send_range(0, 59, 1'b0);
    build_exp(60);
    chk("nolast_valid", 256'(out_valid), 256'(1'b1));
    chk("nolast_flag", 256'(out_nolast), 256'(1'b1));
    chk("nolast_short", 256'(out_short), 256'(1'b0));
    chk("nolast_word", 256'(out_data), 256'(exp_word));
    pop_word();
    chk("nolast_clear", 256'(out_nolast), 256'(1'b0));

    // Backpressure: word held 10 cycles while a slice is offered
    for (int k = 0; k < 60; k++) slices[k] = ~4'(k);
    send_range(0, 59, 1'b1);
    build_exp(60);
    in_valid = 1'b1;
    in_data  = 4'h7;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_in_ready_%0d", c), 256'(in_ready), 256'(1'b0));
      chk($sformatf("bp_word_%0d", c), 256'(out_data), 256'(exp_word));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_popped", 256'(out_valid), 256'(1'b0));
    chk("bp_ready_back", 256'(in_ready), 256'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    slices[0] = 4'h7;
    for (int k = 1; k < 60; k++) slices[k] = 4'(k);
    send_range(1, 59, 1'b1);
    build_exp(60);
    chk("bp_next_word", 256'(out_data), 256'(exp_word));
    pop_word();

    // Flush at count 30 together with in_valid and in_last
    for (int k = 0; k < 30; k++) slices[k] = 4'h5;
    send_range(0, 29, 1'b0);
    in_flush = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 4'hA;
    @(posedge clk);
    #1;
    in_flush = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_valid", 256'(out_valid), 256'(1'b0));
    chk("flush_buf_zero", 256'(out_data), 256'(0));
    chk("flush_in_ready", 256'(in_ready), 256'(1'b1));
    for (int k = 0; k < 60; k++) slices[k] = 4'(k + 3);
    send_range(0, 58, 1'b0);
    chk("flush_next_pre", 256'(out_valid), 256'(1'b0));
    send_range(59, 59, 1'b1);
    build_exp(60);
    chk("flush_next_word", 256'(out_data), 256'(exp_word));
    chk("flush_next_short", 256'(out_short), 256'(1'b0));
    chk("flush_next_nolast", 256'(out_nolast), 256'(1'b0));
    pop_word();

    // Async reset pulsed between clock edges mid-FILL
    for (int k = 0; k < 20; k++) slices[k] = 4'h9;
    send_range(0, 19, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_data", 256'(out_data), 256'(0));
    chk("arst_in_ready", 256'(in_ready), 256'(1'b0));
    chk("arst_out_valid", 256'(out_valid), 256'(1'b0));
    @(posedge clk);
    #1;
    chk("arst_in_ready_hold", 256'(in_ready), 256'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_no_valid", 256'(out_valid), 256'(1'b0));
    for (int k = 0; k < 60; k++) slices[k] = 4'(60 - k);
    send_range(0, 59, 1'b1);
    build_exp(60);
    chk("arst_next_word", 256'(out_data), 256'(exp_word));
    pop_word();

`ifdef PACKED_DESER_XCHECK_EN
    for (int k = 0; k < 7; k++) slices[k] = 4'h0;
    slices[5] = 4'b1z0x;
    send_range(0, 6, 1'b1);
    chk("xz_flag", 256'(out_xz), 256'(1'b1));
    chk("xz_slot", 256'(out_data[0][1][2]), 256'(4'b1z0x));
    pop_word();
    for (int k = 0; k < 60; k++) slices[k] = 4'(k);
    send_range(0, 59, 1'b1);
    chk("xz_clean", 256'(out_xz), 256'(1'b0));
    pop_word();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/packed_word_deserializer.md
Name: packed_word_deserializer

Overview:
- Receive end of the packed-array slice stream produced by the stimulus generators.
- Accepts fixed-width slices over a valid/ready handshake and assembles them into one multi-dimensional packed word, shaped [D3-1:0][D2-1:0][D1-1:0][SLICE_W-1:0] (default 5x4x3x4 = 240 bits).
- Presents the finished word on a second valid/ready handshake, with frame-status flags.
- Sits between the slice serializer and the word-level checkers.

Parameters:
- SLICE_W, 4, bits per incoming slice; also the innermost dimension.
- D1, 3, third packed dimension (slices per row).
- D2, 4, second packed dimension.
- D3, 5, outermost packed dimension.
- Derived constants (not overridable): N_SLICES = D1*D2*D3 = 60; WORD_W = N_SLICES*SLICE_W = 240; CNT_W = $clog2(N_SLICES+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  slice present.
- in_ready  out  1  block accepts the slice this cycle.
- in_data  in  SLICE_W  slice payload, 4-state logic.
- in_last  in  1  final slice of the frame.
- in_flush  in  1  synchronous abort of the frame being assembled.
- out_valid  out  1  assembled word available.
- out_ready  in  1  consumer takes the word.
- out_data  out  [D3-1:0][D2-1:0][D1-1:0][SLICE_W-1:0]  assembled word.
- out_short  out  1  frame ended by in_last before N_SLICES slices.
- out_nolast  out  1  N_SLICES slices received without in_last on the last one.
- out_xz  out  1  X/Z seen in the frame (present only with the macro).

Behaviour:
- Reset (async assert; sync deassert assumed from the reset tree):
  - State IDLE; count = 0.
  - out_data = '0; out_valid, out_short, out_nolast and out_xz = 0.
  - in_ready = 0 while rst is high.
- Transfer rules:
  - A slice transfers when in_valid & in_ready.
  - A word transfers when out_valid & out_ready.
- Fill order:
  - Slice k (0-based) is written to flat bits [k*SLICE_W +: SLICE_W].
  - Slice 0 therefore lands in out_data[0][0][0]; slice 59 lands in out_data[4][3][2].
  - Indexing is in declared-range terms; ranges are normalised to [n-1:0].
- FSM states:
  - IDLE: in_ready = 1. On a transfer: write slice 0, count = 1, go to FILL. If that slice has in_last, go directly to HOLD with out_short = 1 (unless N_SLICES = 1).
  - FILL: in_ready = 1. Each transfer writes slice[count] and increments count.
    - in_last with count+1 < N_SLICES: remaining slices are zeroed, out_short = 1, go to HOLD.
    - count+1 = N_SLICES: go to HOLD. out_nolast = !in_last.
  - HOLD: in_ready = 0; out_valid = 1. out_data and flags stay stable until the word transfers. Then count = 0, flags clear, go to IDLE.
- Latency and throughput:
  - out_valid rises the cycle after the completing slice transfer.
  - Minimum frame period is N_SLICES+1 cycles. No overlap: slices are not accepted in HOLD.
- in_flush:
  - In IDLE or FILL: count = 0, buffer zeroed, flags cleared, go to IDLE. A slice offered in the same cycle is dropped.
  - Ignored in HOLD, since the word is already committed.
- Simultaneous in_flush and in_last: flush wins.
- Reset mid-frame: the partial word is discarded and no out_valid is produced.
- Count never exceeds N_SLICES. Wrap-around is impossible because HOLD blocks input.

Optional Feature:
- Macro: PACKED_DESER_XCHECK_EN.
- Defined:
  - out_xz exists.
  - out_xz is set if any accepted slice of the frame has X or Z on any bit (reduction-XOR compared with ===).
  - It is sticky for the frame and cleared on word transfer, flush and reset.
  - Offending bits are stored unchanged.
- Undefined:
  - Port out_xz is absent.
  - No X/Z comparison logic exists.
  - Payload bits still pass through 4-state.

Decomposition:
- Package packed_deser_pkg holds:
  - default dimension constants;
  - state enum deser_state_e {IDLE, FILL, HOLD};
  - function slice_offset(k) returning k*SLICE_W.
- One sub-module: deser_slice_counter. It holds the count register and exposes inc, clr, count and is_last_slot.

Test Plan:
- Full frame: 60 slices with in_data = k[3:0] and in_last on slice 59.
  - out_valid appears 1 cycle later; out_data[0][0][0] = 4'h0, out_data[0][0][1] = 4'h1, out_data[4][3][2] = 4'hB; out_short = 0, out_nolast = 0.
- Short frame: 7 slices of 4'hF, in_last on slice 6.
  - Flat bits [27:0] are all ones, bits [239:28] are 0; out_short = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after a full frame.
  - in_ready = 0 throughout; out_data is stable.
  - The next frame's slice 0 is accepted only after the word transfer.
- Flush at count = 30, asserted together with in_valid and in_last.
  - Return to IDLE; no out_valid is produced.
  - A following full frame assembles correctly from slice 0.
- Async reset pulsed mid-FILL, between clock edges.
  - Outputs go to their reset values immediately; in_ready = 0 during reset.
- With PACKED_DESER_XCHECK_EN defined: slice 5 = 4'b1z0x.
  - out_xz = 1 and the stored slice reads 4'b1z0x.
  - The next clean frame gives out_xz = 0.
